// File: rtl/dm_store_buffer.sv
// dm_store_buffer: M-stage store formatting, AdES detection and a DEPTH-entry FIFO draining over bus_req/bus_ack.
// Optional macro DM_STB_LOAD_CHECK_EN adds ld_valid/ld_addr/ld_conflict for load-vs-pending-store hazard detection.
module dm_store_buffer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [2:0]  type_ins_M,
  input  logic [1:0]  store_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        st_stall,
  output logic        AdES_sign_dm,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
`ifdef DM_STB_LOAD_CHECK_EN
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
`endif
  input  logic        bus_ack
);

  localparam logic [1:0]       OP_WORD = 2'b01;
  localparam logic [1:0]       OP_HALF = 2'b10;
  localparam logic [1:0]       OP_BYTE = 2'b11;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [31:0]    addr_q [DEPTH];
  logic [3:0]     be_q   [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic        is_store, in_dm, in_t0, in_t1, in_timer;
  logic        full, empty, push, pop;
  logic [3:0]  byteen;
  logic [31:0] rep_data;

  assign is_store = st_valid && (type_ins_M == 3'b101);
  assign in_dm    = (addr <= 32'h0000_2fff);
  assign in_t0    = (addr >= 32'h0000_7f00) && (addr <= 32'h0000_7f0b);
  assign in_t1    = (addr >= 32'h0000_7f10) && (addr <= 32'h0000_7f1b);
  assign in_timer = in_t0 || in_t1;

  always_comb begin
    AdES_sign_dm = 1'b0;
    if (is_store) begin
      if (store_op == OP_WORD && addr[1:0] != 2'b00) AdES_sign_dm = 1'b1;
      if (store_op == OP_HALF && addr[0]) AdES_sign_dm = 1'b1;
      if (!(in_dm || in_timer)) AdES_sign_dm = 1'b1;
      if ((store_op == OP_HALF || store_op == OP_BYTE) && in_timer) AdES_sign_dm = 1'b1;
      // COUNT registers at timer offset 8 are read-only
      if (store_op == OP_WORD && (addr == 32'h0000_7f08 || addr == 32'h0000_7f18))
        AdES_sign_dm = 1'b1;
    end
  end

  always_comb begin
    byteen   = 4'b0000;
    rep_data = 32'h0;
    case (store_op)
      OP_WORD: begin
        byteen   = 4'b1111;
        rep_data = wdata;
      end
      OP_HALF: begin
        byteen   = addr[1] ? 4'b1100 : 4'b0011;
        rep_data = {2{wdata[15:0]}};
      end
      OP_BYTE: begin
        byteen   = 4'b0001 << addr[1:0];
        rep_data = {4{wdata[7:0]}};
      end
      default: begin
        byteen   = 4'b0000;
        rep_data = 32'h0;
      end
    endcase
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = is_store && (store_op != 2'b00) && !AdES_sign_dm && !flush && !full;
  assign pop   = bus_req && bus_ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 32'h0;
        be_q[i]   <= 4'h0;
        data_q[i] <= 32'h0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= {addr[31:2], 2'b00};
        be_q[wr_ptr]   <= byteen;
        data_q[wr_ptr] <= rep_data;
        wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign st_stall   = full;
  assign bus_req    = !empty;
  assign bus_addr   = addr_q[rd_ptr];
  assign bus_byteen = be_q[rd_ptr];
  assign bus_wdata  = data_q[rd_ptr];

`ifdef DM_STB_LOAD_CHECK_EN
  logic [PTR_W-1:0] age;

  // Entry i is live when its distance from the head is below count
  always_comb begin
    ld_conflict = 1'b0;
    age         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PTR_W'(i) - rd_ptr;
      if (ld_valid && ({1'b0, age} < count) && (addr_q[i] == {ld_addr[31:2], 2'b00}))
        ld_conflict = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer (DEPTH=2).
module tb_dm_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [2:0]  type_ins_M;
  logic [1:0]  store_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        st_stall;
  logic        AdES_sign_dm;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
`ifdef DM_STB_LOAD_CHECK_EN
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(2), .PTR_W(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .type_ins_M   (type_ins_M),
    .store_op     (store_op),
    .addr         (addr),
    .wdata        (wdata),
    .flush        (flush),
    .st_stall     (st_stall),
    .AdES_sign_dm (AdES_sign_dm),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_byteen   (bus_byteen),
    .bus_wdata    (bus_wdata),
`ifdef DM_STB_LOAD_CHECK_EN
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_conflict  (ld_conflict),
`endif
    .bus_ack      (bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a store in M; comb outputs settle after #1
  task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid   = 1'b1;
    type_ins_M = 3'b101;
    store_op   = op;
    addr       = a;
    wdata      = d;
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0;
    store_op = 2'b00;
    #1;
  endtask

  initial begin
    reset = 1'b0; st_valid = 1'b0; type_ins_M = 3'b000; store_op = 2'b00;
    addr = 32'h0; wdata = 32'h0; flush = 1'b0; bus_ack = 1'b0;
`ifdef DM_STB_LOAD_CHECK_EN
    ld_valid = 1'b0; ld_addr = 32'h0;
`endif
    tick();
    reset = 1'b1;
    #1;
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_st_stall", {31'h0, st_stall}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_byteen", {28'h0, bus_byteen}, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);

    // sh to 0x6 -> upper half lanes
    present(2'b10, 32'h0000_0006, 32'h1234_ABCD);
    check("sh6_ades", {31'h0, AdES_sign_dm}, 32'h0);
    check("sh6_req_before_edge", {31'h0, bus_req}, 32'h0);
    tick();
    idle();
    check("sh6_req", {31'h0, bus_req}, 32'h1);
    check("sh6_addr", bus_addr, 32'h0000_0004);
    check("sh6_byteen", {28'h0, bus_byteen}, 32'hC);
    check("sh6_wdata", bus_wdata, 32'hABCD_ABCD);

    // sb to 0x3 fills the FIFO; head must stay on the sh
    present(2'b11, 32'h0000_0003, 32'h0000_00EE);
    check("sb3_ades", {31'h0, AdES_sign_dm}, 32'h0);
    tick();
    idle();
    check("sb3_stall", {31'h0, st_stall}, 32'h1);
    check("sb3_head_addr", bus_addr, 32'h0000_0004);
    check("sb3_head_wdata", bus_wdata, 32'hABCD_ABCD);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #1;
    check("sb3_addr", bus_addr, 32'h0000_0000);
    check("sb3_byteen", {28'h0, bus_byteen}, 32'h8);
    check("sb3_wdata", bus_wdata, 32'hEEEE_EEEE);
    check("sb3_stall_cleared", {31'h0, st_stall}, 32'h0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #1;
    check("drain1_req", {31'h0, bus_req}, 32'h0);

    // AdES cases
    present(2'b01, 32'h0000_7f08, 32'h1);
    check("ades_sw_count", {31'h0, AdES_sign_dm}, 32'h1);
    tick();
    check("ades_no_push", {31'h0, bus_req}, 32'h0);
    present(2'b01, 32'h0000_7f18, 32'h1);
    check("ades_sw_count1", {31'h0, AdES_sign_dm}, 32'h1);
    present(2'b10, 32'h0000_7f00, 32'h1);
    check("ades_sh_timer", {31'h0, AdES_sign_dm}, 32'h1);
    present(2'b11, 32'h0000_7f13, 32'h1);
    check("ades_sb_timer", {31'h0, AdES_sign_dm}, 32'h1);
    present(2'b01, 32'h0000_3000, 32'h1);
    check("ades_sw_outside", {31'h0, AdES_sign_dm}, 32'h1);
    present(2'b01, 32'h0000_0002, 32'h1);
    check("ades_sw_misalign", {31'h0, AdES_sign_dm}, 32'h1);
    present(2'b10, 32'h0000_0005, 32'h1);
    check("ades_sh_odd", {31'h0, AdES_sign_dm}, 32'h1);
    present(2'b01, 32'h0000_7f0c, 32'h1);
    check("ades_sw_t0_gap", {31'h0, AdES_sign_dm}, 32'h1);
    present(2'b01, 32'h0000_7f14, 32'h1);
    check("ok_sw_t1", {31'h0, AdES_sign_dm}, 32'h0);
    present(2'b11, 32'h0000_2fff, 32'h1);
    check("ok_sb_dm_top", {31'h0, AdES_sign_dm}, 32'h0);
    type_ins_M = 3'b000;
    addr = 32'h0000_3000;
    store_op = 2'b01;
    #1;
    check("ok_not_store", {31'h0, AdES_sign_dm}, 32'h0);
    idle();

    // Full FIFO: third store must survive the stall
    present(2'b01, 32'h0000_0000, 32'h0000_00A0);
    tick();
    present(2'b01, 32'h0000_0004, 32'h0000_00A4);
    tick();
    check("full_stall", {31'h0, st_stall}, 32'h1);
    present(2'b01, 32'h0000_0008, 32'h0000_00A8);
    tick();
    check("full_stall_hold", {31'h0, st_stall}, 32'h1);
    check("full_head0_addr", bus_addr, 32'h0000_0000);
    check("full_head0_wdata", bus_wdata, 32'h0000_00A0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #1;
    check("full_pop_stall", {31'h0, st_stall}, 32'h0);
    check("full_head1_addr", bus_addr, 32'h0000_0004);
    tick();
    idle();
    check("full_third_in", {31'h0, st_stall}, 32'h1);
    check("full_head1_hold", bus_wdata, 32'h0000_00A4);
    bus_ack = 1'b1;
    tick();
    check("full_head2_addr", bus_addr, 32'h0000_0008);
    check("full_head2_wdata", bus_wdata, 32'h0000_00A8);
    tick();
    check("full_drained", {31'h0, bus_req}, 32'h0);
    tick();
    check("stray_ack_req", {31'h0, bus_req}, 32'h0);
    check("stray_ack_stall", {31'h0, st_stall}, 32'h0);
    bus_ack = 1'b0;

    // Simultaneous push/pop at count 1 across pointer wraps
    present(2'b01, 32'h0000_0010, 32'h0000_0010);
    tick();
    for (int k = 0; k < 4; k++) begin
      present(2'b01, 32'h0000_0020 + 32'(4 * k), 32'h0000_0100 + 32'(k));
      bus_ack = 1'b1;
      tick();
      check("pp_req", {31'h0, bus_req}, 32'h1);
      check("pp_stall", {31'h0, st_stall}, 32'h0);
      check("pp_addr", bus_addr, 32'h0000_0020 + 32'(4 * k));
      check("pp_wdata", bus_wdata, 32'h0000_0100 + 32'(k));
    end
    idle();
    tick();
    bus_ack = 1'b0;
    #1;
    check("pp_drained", {31'h0, bus_req}, 32'h0);

    // Flush suppresses the push
    flush = 1'b1;
    present(2'b01, 32'h0000_0010, 32'h5555_5555);
    tick();
    flush = 1'b0;
    idle();
    check("flush_no_push", {31'h0, bus_req}, 32'h0);

`ifdef DM_STB_LOAD_CHECK_EN
    present(2'b01, 32'h0000_0004, 32'h7777_7777);
    tick();
    idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0007;
    #1;
    check("ld_conflict_hit", {31'h0, ld_conflict}, 32'h1);
    ld_addr = 32'h0000_0008;
    #1;
    check("ld_conflict_miss", {31'h0, ld_conflict}, 32'h0);
    ld_addr = 32'h0000_0007;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #1;
    check("ld_conflict_drained", {31'h0, ld_conflict}, 32'h0);
    ld_valid = 1'b0;
`endif

    // Reset with two pending entries discards them
    present(2'b01, 32'h0000_0040, 32'h1111_1111);
    tick();
    present(2'b01, 32'h0000_0044, 32'h2222_2222);
    tick();
    idle();
    check("prerst_stall", {31'h0, st_stall}, 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rst2_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst2_st_stall", {31'h0, st_stall}, 32'h0);
    check("rst2_bus_addr", bus_addr, 32'h0);
    check("rst2_bus_byteen", {28'h0, bus_byteen}, 32'h0);
    check("rst2_bus_wdata", bus_wdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
